mem_bus_arbiter: RTL and testbench

- Shares the single memory-controller port (16-bit address, write enable, WIDTH data) between two requesters: m0 = CPU load/store path, m1 = DMA/VGA-refresh engine.
- Round-robin arbitration with a req/gnt/rvalid handshake.
- Sits between the requesters and the memory controller. The memory controller still decodes address bits [15:14] into data RAM, stack, VGA and IO regions; this block does no decoding.

---
 rtl/mem_bus_arbiter_if.sv | 38 +++
 rtl/mem_bus_arbiter.sv | 102 ++++++++++
 tb/tb_mem_bus_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: bundle of the two requester ports and the memory
// controller port around mem_bus_arbiter.
//   m0_* / m1_* : req/we/addr/wdata in, gnt/rvalid/rdata out (per requester)
//   mc_*        : addr/wdata/we toward the memory controller, rdata back
// modport slave  : the arbiter's view (serves requesters, drives the mc port)
// modport master : the environment's view (requesters plus memory controller)
interface mem_bus_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 16
);
  logic              m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [ADDR_W-1:0] m0_addr;
  logic [WIDTH-1:0]  m0_wdata, m0_rdata;
  logic              m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [ADDR_W-1:0] m1_addr;
  logic [WIDTH-1:0]  m1_wdata, m1_rdata;
  logic [ADDR_W-1:0] mc_addr;
  logic [WIDTH-1:0]  mc_wdata, mc_rdata;
  logic              mc_we;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mc_addr, mc_wdata, mc_we,
    input  mc_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mc_addr, mc_wdata, mc_we,
    output mc_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin share of one memory-controller port between
// requester 0 (CPU load/store) and requester 1 (DMA / VGA refresh).
// One transaction at a time: IDLE (sample reqs) -> ACCESS (gnt, mc_* valid)
// -> RDWAIT (reads only, READ_LAT cycles) -> IDLE.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : requester and memory-controller signals (slave modport)
module mem_bus_arbiter #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 16,
  parameter int READ_LAT = 1    // 1..4
) (
  input  logic             clk,
  input  logic             reset_n,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

  state_t                  state, state_nxt;
  logic                    owner, last_owner, we_q;
  logic [2:0]              cnt;
  logic [ADDR_W-1:0]       addr_q;
  logic [WIDTH-1:0]        wdata_q;
  logic [1:0][WIDTH-1:0]   rdata_q;
  logic [1:0]              req, gnt, rvalid;
  logic                    take, win;

  assign req = {bus.m1_req, bus.m0_req};

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    win       = 1'b0;
    gnt       = '0;
    rvalid    = '0;
    case (state)
      IDLE: begin
        if (|req) begin
          take      = 1'b1;
          // on a tie the requester that did not go last wins
          win       = (req == 2'b11) ? ~last_owner : req[1];
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        gnt[owner] = 1'b1;
        state_nxt  = we_q ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        if (cnt == 3'd1) begin
          rvalid[owner] = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      we_q       <= 1'b0;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        owner   <= win;
        we_q    <= win ? bus.m1_we    : bus.m0_we;
        addr_q  <= win ? bus.m1_addr  : bus.m0_addr;
        wdata_q <= win ? bus.m1_wdata : bus.m0_wdata;
      end
      if (state == ACCESS) begin
        last_owner <= owner;
        if (!we_q) cnt <= 3'(READ_LAT);
      end else if (state == RDWAIT) begin
        cnt <= cnt - 3'd1;
      end
      if (rvalid[0]) rdata_q[0] <= bus.mc_rdata;
      if (rvalid[1]) rdata_q[1] <= bus.mc_rdata;
    end
  end

  // mc_addr/mc_wdata hold between transactions; mc_we only in a write ACCESS
  assign bus.mc_addr   = addr_q;
  assign bus.mc_wdata  = wdata_q;
  assign bus.mc_we     = (state == ACCESS) && we_q;

  assign bus.m0_gnt    = gnt[0];
  assign bus.m1_gnt    = gnt[1];
  assign bus.m0_rvalid = rvalid[0];
  assign bus.m1_rvalid = rvalid[1];
  // read data passes straight through in the rvalid cycle, then holds
  assign bus.m0_rdata  = rvalid[0] ? bus.mc_rdata : rdata_q[0];
  assign bus.m1_rdata  = rvalid[1] ? bus.mc_rdata : rdata_q[1];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: two arbiters (READ_LAT 1 and 3) driven with directed
// vectors; a transaction-schedule model predicts every output each cycle,
// and hand-computed literal checks pin key cycles.
module tb_mem_bus_arbiter;
  localparam int W = 32;
  localparam int A = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.WIDTH(W), .ADDR_W(A)) bus_a ();
  mem_bus_arbiter_if #(.WIDTH(W), .ADDR_W(A)) bus_b ();

  mem_bus_arbiter #(.WIDTH(W), .ADDR_W(A), .READ_LAT(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a));
  mem_bus_arbiter #(.WIDTH(W), .ADDR_W(A), .READ_LAT(3)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b));

  // memory contents seen by both arbiters
  function automatic logic [W-1:0] mem_f(logic [A-1:0] a);
    return (a == 16'h8004) ? 32'h0000_005A : {~a, a};
  endfunction

  assign bus_a.mc_rdata = mem_f(bus_a.mc_addr);
  assign bus_b.mc_rdata = mem_f(bus_b.mc_addr);

  typedef struct packed {
    logic g0, g1, rv0, rv1, we;
    logic [A-1:0] addr;
    logic [W-1:0] wd, rd0, rd1;
  } obs_t;

  typedef struct packed {
    logic r0, w0; logic [A-1:0] a0; logic [W-1:0] d0;
    logic r1, w1; logic [A-1:0] a1; logic [W-1:0] d1;
  } rq_t;

  obs_t act [2];
  rq_t  rq  [2];

  assign act[0] = {bus_a.m0_gnt, bus_a.m1_gnt, bus_a.m0_rvalid, bus_a.m1_rvalid,
                   bus_a.mc_we, bus_a.mc_addr, bus_a.mc_wdata, bus_a.m0_rdata, bus_a.m1_rdata};
  assign act[1] = {bus_b.m0_gnt, bus_b.m1_gnt, bus_b.m0_rvalid, bus_b.m1_rvalid,
                   bus_b.mc_we, bus_b.mc_addr, bus_b.mc_wdata, bus_b.m0_rdata, bus_b.m1_rdata};
  assign rq[0]  = {bus_a.m0_req, bus_a.m0_we, bus_a.m0_addr, bus_a.m0_wdata,
                   bus_a.m1_req, bus_a.m1_we, bus_a.m1_addr, bus_a.m1_wdata};
  assign rq[1]  = {bus_b.m0_req, bus_b.m0_we, bus_b.m0_addr, bus_b.m0_wdata,
                   bus_b.m1_req, bus_b.m1_we, bus_b.m1_addr, bus_b.m1_wdata};

  int vec  = 0;
  int miss = 0;

  // ---------------- transaction-schedule model ----------------
  typedef struct {
    bit g, gw, we, rv, rw;
    logic [A-1:0] addr;
    logic [W-1:0] wd;
  } slot_t;

  int           lat [2] = '{1, 3};
  int           cyc = 0;
  int           free_at [2];
  bit           lastw [2];
  slot_t        sl [2][8];
  logic [A-1:0] h_addr [2];
  logic [W-1:0] h_wd [2];
  logic [W-1:0] h_rd [2][2];

  task automatic model_step(int i);
    obs_t e;
    rq_t  r;
    int   s, n;
    bit   w;
    s = cyc % 8;
    r = rq[i];
    e = '0;
    if (!reset_n) begin
      free_at[i] = 0; lastw[i] = 1'b1;
      h_addr[i] = '0; h_wd[i] = '0; h_rd[i][0] = '0; h_rd[i][1] = '0;
      for (int k = 0; k < 8; k++) sl[i][k] = '{default: '0};
    end else begin
      if (sl[i][s].g) begin
        h_addr[i] = sl[i][s].addr;
        h_wd[i]   = sl[i][s].wd;
        e.we      = sl[i][s].we;
        if (sl[i][s].gw) e.g1 = 1'b1; else e.g0 = 1'b1;
      end
      if (sl[i][s].rv) begin
        if (sl[i][s].rw) begin e.rv1 = 1'b1; h_rd[i][1] = mem_f(h_addr[i]); end
        else             begin e.rv0 = 1'b1; h_rd[i][0] = mem_f(h_addr[i]); end
      end
      sl[i][s] = '{default: '0};
      e.addr = h_addr[i]; e.wd = h_wd[i]; e.rd0 = h_rd[i][0]; e.rd1 = h_rd[i][1];
      if (cyc >= free_at[i] && (r.r0 || r.r1)) begin
        w = (r.r0 && r.r1) ? !lastw[i] : r.r1;
        lastw[i] = w;
        n = (cyc + 1) % 8;
        sl[i][n].g    = 1'b1;
        sl[i][n].gw   = w;
        sl[i][n].we   = w ? r.w1 : r.w0;
        sl[i][n].addr = w ? r.a1 : r.a0;
        sl[i][n].wd   = w ? r.d1 : r.d0;
        if (!sl[i][n].we) begin
          sl[i][(cyc + 1 + lat[i]) % 8].rv = 1'b1;
          sl[i][(cyc + 1 + lat[i]) % 8].rw = w;
          free_at[i] = cyc + 2 + lat[i];
        end else begin
          free_at[i] = cyc + 2;
        end
      end
    end
    vec++;
    if (e !== act[i]) begin
      miss++;
      $display("FAIL cycle inst%0d cyc%0d: got %h want %h", i, cyc, act[i], e);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    model_step(0);
    model_step(1);
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(string n, logic [127:0] got, logic [127:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %0h want %0h", n, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(int inst, int p, bit r, bit we, logic [A-1:0] a, logic [W-1:0] d);
    if (inst == 0) begin
      if (p == 0) begin bus_a.m0_req = r; bus_a.m0_we = we; bus_a.m0_addr = a; bus_a.m0_wdata = d; end
      else        begin bus_a.m1_req = r; bus_a.m1_we = we; bus_a.m1_addr = a; bus_a.m1_wdata = d; end
    end else begin
      if (p == 0) begin bus_b.m0_req = r; bus_b.m0_we = we; bus_b.m0_addr = a; bus_b.m0_wdata = d; end
      else        begin bus_b.m1_req = r; bus_b.m1_we = we; bus_b.m1_addr = a; bus_b.m1_wdata = d; end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) drv(i, p, 0, 0, '0, '0);
    #1;
    chk("reset outputs a", act[0], '0);
    chk("reset outputs b", act[1], '0);
    repeat (2) step();

    // m0 write, then m1 read from the VGA region (READ_LAT 1)
    reset_n = 1'b1;
    drv(0, 0, 1, 1, 16'h0010, 32'hDEAD_BEEF);
    step();
    chk("t1 m0_gnt", bus_a.m0_gnt, 1);
    chk("t1 mc_we", bus_a.mc_we, 1);
    chk("t1 mc_addr", bus_a.mc_addr, 16'h0010);
    chk("t1 mc_wdata", bus_a.mc_wdata, 32'hDEAD_BEEF);
    chk("t1 m1 quiet", {bus_a.m1_gnt, bus_a.m1_rvalid, bus_a.m1_rdata}, '0);
    drv(0, 0, 0, 0, '0, '0);
    step();
    chk("t1 we drop", bus_a.mc_we, 0);
    chk("t1 addr hold", bus_a.mc_addr, 16'h0010);
    drv(0, 1, 1, 0, 16'h8004, '0);
    step();
    chk("t2 m1_gnt", bus_a.m1_gnt, 1);
    chk("t2 mc_we", bus_a.mc_we, 0);
    chk("t2 mc_addr", bus_a.mc_addr, 16'h8004);
    drv(0, 1, 0, 0, '0, '0);
    step();
    chk("t2 m1_rvalid", bus_a.m1_rvalid, 1);
    chk("t2 m1_rdata", bus_a.m1_rdata, 32'h5A);
    chk("t2 mc_we rd", bus_a.mc_we, 0);
    step();
    chk("t2 rvalid drop", bus_a.m1_rvalid, 0);
    chk("t2 rdata hold", bus_a.m1_rdata, 32'h5A);

    // simultaneous writes straight after reset: m0, m1, m0, m1 two cycles apart
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    drv(0, 0, 1, 1, 16'h0100, 32'h1111_1111);
    drv(0, 1, 1, 1, 16'h0200, 32'h2222_2222);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("t3 gnt k%0d", k), {bus_a.m0_gnt, bus_a.m1_gnt}, {k % 4 == 1, k % 4 == 3});
    end
    drv(0, 0, 0, 0, '0, '0);
    drv(0, 1, 0, 0, '0, '0);
    step();

    // m0 read held, m1 write arrives mid-read: m1 next, then m0 again
    drv(0, 0, 1, 0, 16'h4000, '0);
    step();
    chk("t4 m0_gnt", bus_a.m0_gnt, 1);
    drv(0, 1, 1, 1, 16'h0300, 32'h3333_3333);
    step();
    chk("t4 m0_rvalid", bus_a.m0_rvalid, 1);
    chk("t4 m0_rdata", bus_a.m0_rdata, 32'hBFFF_4000);
    step();
    chk("t4 idle no gnt", {bus_a.m0_gnt, bus_a.m1_gnt}, 2'b00);
    step();
    chk("t4 m1 next", {bus_a.m0_gnt, bus_a.m1_gnt}, 2'b01);
    chk("t4 m1 write", {bus_a.mc_we, bus_a.mc_addr}, {1'b1, 16'h0300});
    drv(0, 1, 0, 0, '0, '0);
    step();
    step();
    chk("t4 m0 again", {bus_a.m0_gnt, bus_a.m1_gnt}, 2'b10);
    drv(0, 0, 0, 0, '0, '0);
    repeat (2) step();

    // READ_LAT 3: rvalid three cycles after gnt, m1 kept out meanwhile
    drv(1, 0, 1, 0, 16'h4008, '0);
    step();
    chk("t5 m0_gnt", bus_b.m0_gnt, 1);
    drv(1, 0, 0, 0, '0, '0);
    drv(1, 1, 1, 1, 16'h0400, 32'h4444_4444);
    for (int k = 2; k <= 4; k++) begin
      step();
      chk($sformatf("t5 no gnt k%0d", k), {bus_b.m0_gnt, bus_b.m1_gnt}, 2'b00);
      chk($sformatf("t5 rvalid k%0d", k), bus_b.m0_rvalid, k == 4);
    end
    chk("t5 m0_rdata", bus_b.m0_rdata, 32'hBFF7_4008);
    step();
    step();
    chk("t5 m1_gnt", bus_b.m1_gnt, 1);
    drv(1, 1, 0, 0, '0, '0);
    step();

    // reset during RDWAIT: outputs clear at once, read abandoned
    drv(1, 0, 1, 0, 16'h4010, '0);
    step();
    chk("t6 m0_gnt", bus_b.m0_gnt, 1);
    drv(1, 0, 0, 0, '0, '0);
    step();
    reset_n = 1'b0;
    #1;
    chk("t6 async clear b", act[1], '0);
    chk("t6 async clear a", act[0], '0);
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t6 no rvalid k%0d", k), {bus_b.m0_rvalid, bus_b.m1_rvalid}, 2'b00);
      step();
    end
    drv(1, 0, 1, 1, 16'h0500, 32'h5555_5555);
    drv(1, 1, 1, 1, 16'h0600, 32'h6666_6666);
    step();
    chk("t6 tie m0 first", {bus_b.m0_gnt, bus_b.m1_gnt}, 2'b10);
    drv(1, 0, 0, 0, '0, '0);
    step();
    step();
    chk("t6 then m1", {bus_b.m0_gnt, bus_b.m1_gnt}, 2'b01);
    drv(1, 1, 0, 0, '0, '0);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
